// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
// State encoding is fixed because state_o exposes it for debug.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int unsigned RST_CYCLES_DEF    = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 50000;
  localparam int unsigned STABLE_CYCLES_DEF = 1024;
  localparam int unsigned MAX_RETRIES_DEF   = 3;
  localparam int unsigned LOSS_CNT_W_DEF    = 8;

  // Shared cycle counter width: enough to hold the largest terminal count.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Retry counter width; never narrower than one bit.
  function automatic int unsigned retry_width(input int unsigned max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and downstream-side signals of the lock sequencer.
// master: the sequencer. slave: PLL wrapper / downstream / environment.
// loss_cnt is present only when PLL_SEQ_LOSS_CNT_EN is defined.
// Handshake: relock_req is a single-cycle pulse in the refclk domain; it has
// no ready/acknowledge, the sequencer always accepts it on the edge it is seen.
interface pll_lock_sequencer_if #(
  parameter int unsigned RETRY_W    = 2,
  parameter int unsigned LOSS_CNT_W = 8
);
  logic               pll_locked;
  logic               relock_req;
  logic               pll_rst;
  logic               sys_rst_n;
  logic               ready;
  logic               fault;
  logic [2:0]         state_o;
  logic [RETRY_W-1:0] retry_cnt;
`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, sys_rst_n, ready, fault, state_o, retry_cnt, loss_cnt
  );
  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, sys_rst_n, ready, fault, state_o, retry_cnt, loss_cnt
  );
`else
  modport master (
    input  pll_locked, relock_req,
    output pll_rst, sys_rst_n, ready, fault, state_o, retry_cnt
  );
  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, sys_rst_n, ready, fault, state_o, retry_cnt
  );
`endif
endinterface

// File: rtl/pll_lock_sequencer_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: holds the PLL in reset, qualifies lock, releases the
// downstream reset, retries on timeout, latches a fault, re-sequences on lock loss.
// Optional lock-loss counter: define PLL_SEQ_LOSS_CNT_EN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRIES   = MAX_RETRIES_DEF,
  parameter int unsigned LOSS_CNT_W    = LOSS_CNT_W_DEF
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  pll_lock_sequencer_if.master bus
);

  localparam int unsigned CNT_W   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RETRY_W = retry_width(MAX_RETRIES);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic lk;

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic pll_rst_q, pll_rst_d;
  logic sys_rst_n_q, sys_rst_n_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;

  bit_sync u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (lk)
  );

  // State, counters and registered Moore outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next state and counters; relock_req overrides every other transition.
  // Outputs decode the next state so they move on the same edge as state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RESET_PLL;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE: begin
        // A single low cycle restarts lock qualification without a retry.
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
        retry_d = '0;
      end
    endcase

    if (bus.relock_req) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end

    pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  // Count RUN exits caused by lock loss, independent of a coincident relock_req.
  always_comb begin
    loss_d = loss_q;
    if ((state_q == ST_RUN) && !lk && (loss_q != {LOSS_CNT_W{1'b1}})) begin
      loss_d = loss_q + 1'b1;
    end
  end

  // Lock-loss counter register; only rst_n clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign bus.loss_cnt = loss_q;
`endif

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.state_o   = state_q;
  assign bus.retry_cnt = retry_q;

endmodule
